// File: rtl/nsa_pkg.sv
// Shared types and sizing for the nibble-serial adder: FSM states, slice width
// and the nibble-counter width helper.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_e;

  localparam int SLICE_W     = 4;
  localparam int NSA_WIDTH   = 16;
  localparam int NSA_NIBBLES = NSA_WIDTH / SLICE_W;

  // A single-nibble build still needs a one-bit counter.
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

  localparam int NSA_CNT_W = cnt_w(NSA_NIBBLES);

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
module nibble_add_slice (
  input  logic [3:0] p,
  input  logic [3:0] q,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = p[i] ^ q[i] ^ c[i];
    assign c[i+1] = (p[i] & q[i]) | (c[i] & (p[i] ^ q[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_add16.sv
// WIDTH-bit add (or subtract, when built with NSA_SUB_EN) done one nibble per
// cycle through a single shared 4-bit slice, LS nibble first.
module nibble_serial_add16
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CNT_W   = cnt_w(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  nsa_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [SLICE_W-1:0] p_nib, q_nib, s_nib;
  logic               s_co;

`ifdef NSA_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  // Nibble-select mux in front of the one shared slice.
  always_comb begin
    p_nib = '0;
    q_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        p_nib = a_q[k*SLICE_W +: SLICE_W];
        q_nib = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  nibble_add_slice u_slice (
    .p  (p_nib),
    .q  (q_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (s_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = c_eff;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*SLICE_W +: SLICE_W] = s_nib;
        end
        carry_d = s_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = s_co;
          // The slice output is the MSB nibble here, so s_nib's top bit is sum[MSB].
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[SLICE_W-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed, table-driven bench for nibble_serial_add16 plus hand-written
// backpressure and mid-RUN reset sequences.
module tb_nibble_serial_add16;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_add16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    string       name;
    logic [15:0] va, vb;
    logic        vcin, vsub;
    logic [15:0] esum;
    logic        ecout, eovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one operand set, waits for the result with a bounded loop and
  // returns outputs plus latency counted from the accept cycle.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                       input logic vsub, output logic [15:0] rsum, output logic rcout,
                       output logic rovf, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = va; b = vb; cin = vcin; sub = vsub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rsum = sum; rcout = cout; rovf = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        vecs[8];
  logic [15:0] rs;
  logic        rc, ro;
  int          lat;

  initial begin
    vecs[0] = '{"add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_7fff_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{"add_abcd_1111", 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
    vecs[5] = '{"add_0f0f_00f1", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
`ifdef NSA_SUB_EN
    vecs[6] = '{"sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{"sub_8000_1",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
    vecs[6] = '{"sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
    vecs[7] = '{"sub_8000_1",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready1", {31'd0, in_ready},  32'd1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, rs, rc, ro, lat);
      chk({vecs[i].name, "_sum"},  {16'd0, rs}, {16'd0, vecs[i].esum});
      chk({vecs[i].name, "_cout"}, {31'd0, rc}, {31'd0, vecs[i].ecout});
      chk({vecs[i].name, "_ovf"},  {31'd0, ro}, {31'd0, vecs[i].eovf});
      chk({vecs[i].name, "_lat"},  lat,         32'd5);
    end

    // Backpressure: result held while new operands are ignored
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 32'd5);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_sum",       {16'd0, sum},       32'h5555);
      chk("bp_cout",      {31'd0, cout},      32'd0);
      chk("bp_ovf",       {31'd0, ovf},       32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_new_lat", lat,           32'd5);
    chk("bp_new_sum", {16'd0, sum},  32'h3333);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after two nibbles of RUN
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum",       {16'd0, sum},       32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      chk("mid_rst_no_stale", stale, 32'd0);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_rst_sum", {16'd0, rs}, 32'h0002);
    chk("post_rst_lat", lat,         32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add16.md
# nibble_serial_add16

Sequential controller that performs a WIDTH-bit addition or subtraction by reusing a single 4-bit ripple-carry adder slice once per nibble, least-significant nibble first. The controller holds the running carry in a register between slices. It trades latency for area against a full-width ripple-carry adder. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NIBBLES = WIDTH/4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add
- sub  input  1  1 = compute a − b (only honoured with NSA_SUB_EN)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB nibble
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE, nibble counter = 0
  - sum = 0, cout = 0, ovf = 0, out_valid = 0
  - in_ready = 0 during the reset cycle, then 1
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture a, b_eff and c_eff, clear the counter and go to RUN.
  - b_eff = sub_active ? ~b : b.
  - c_eff = sub_active ? 1 : cin. cin is ignored when sub_active.
- RUN:
  - in_ready = 0.
  - Each cycle, apply nibble k of a and b_eff plus the carry register to the slice.
  - Write the slice sum into sum[4k+3:4k] and the slice carry into the carry register; increment k.
  - After the nibble with k = NIBBLES−1: cout = slice carry; ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); go to DONE.
- DONE:
  - out_valid = 1. sum, cout and ovf are held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - No same-cycle restart: in_ready stays 0 in DONE.
- in_valid outside IDLE is ignored; operands are not queued.
- sum, cout and ovf keep their last values in IDLE until the next accept overwrites them.
- rst in any state, including mid-RUN: the operation is abandoned, reset values apply on the next edge, and no result is emitted.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry out; for subtraction cout = 1 means no borrow.

## Timing
- Accept at the end of cycle T; RUN occupies cycles T+1 … T+NIBBLES; out_valid is first high in cycle T+NIBBLES+1. For WIDTH=16, that is T+5.
- Minimum initiation interval is NIBBLES+2 cycles (6 for WIDTH=16), with out_ready held high.
- The slice is purely combinational between the operand/carry registers and the result registers: one slice delay per cycle.
- out_valid stays high indefinitely until out_ready is sampled high.

## Configuration
- NSA_SUB_EN defined:
  - sub_active = sub.
  - Subtraction is performed by inverting b and forcing the carry-in to 1.
- NSA_SUB_EN undefined:
  - sub_active = 0; the sub port is present but ignored.
  - Only a + b + cin is computed; no inverter logic is built.

## Structure
- Shared package nsa_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - SLICE_W = 4
  - the counter width derived from NIBBLES
- One sub-module, nibble_add_slice:
  - combinational 4-bit ripple-carry adder built from four full-adder cells
  - ports p[3:0], q[3:0], ci, s[3:0], co
  - instantiated exactly once in the controller.

## Test plan
- 0x1234 + 0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid first high exactly 5 cycles after the accept cycle.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; the carry must propagate across all four nibble steps.
- 0x7FFF + 0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- a=0x0005, b=0x0007, sub=1:
  - with NSA_SUB_EN → sum=0xFFFE, cout=0, ovf=0
  - without NSA_SUB_EN → sum=0x000C, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid with new operands → sum/cout/ovf stable, in_ready=0, new operands not taken. Release out_ready → IDLE next cycle; the re-presented operands are then accepted and computed correctly.
- Assert rst for one cycle during RUN (after 2 nibbles) → next cycle state IDLE, out_valid=0, sum=0, in_ready=1; no stale result appears; the following operation 0x0001 + 0x0001 yields sum=0x0002.
